seq_gen: RTL and testbench



---
 rtl/seq_gen_pkg.sv | 12 +
 rtl/seq_gen.sv | 100 ++++++++++
 tb/tb_seq_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and
// the default pattern width.
package seq_gen_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/seq_gen.sv
// Serial pattern transmitter: loads a pattern word and shifts it out LSB-first,
// single-shot or looping, feeding the downstream sequence detector.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_repeat,
    input  logic             i_stop,
    output logic             o_ready,
    output logic             o_valid,
    output logic             o_val,
    output logic             o_last,
    output logic             o_done
);

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] nxt_idx;
    logic [CNT_W-1:0] len_q;
    logic [WIDTH-1:0] pat_q;
    logic             rep_q;
    logic             stop_pend;

    // idx never exceeds len_q, so the increment cannot wrap past WIDTH-1.
    assign nxt_idx = idx + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            rep_q     <= 1'b0;
            stop_pend <= 1'b0;
            o_ready   <= 1'b0;
            o_valid   <= 1'b0;
            o_val     <= 1'b0;
            o_last    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_val   <= 1'b0;
                    o_last  <= 1'b0;
                    if (i_load && o_ready) begin
                        pat_q     <= i_pattern;
                        len_q     <= i_len;
                        rep_q     <= i_repeat;
                        stop_pend <= 1'b0;
                        idx       <= '0;
                        state     <= ST_SEND;
                        o_ready   <= 1'b0;
                        o_valid   <= 1'b1;
                        o_val     <= i_pattern[0];
                        o_last    <= (i_len == '0);
                    end
                end

                ST_SEND: begin
                    o_done <= 1'b0;
                    if (idx != len_q) begin
                        idx       <= nxt_idx;
                        o_val     <= pat_q[nxt_idx];
                        o_last    <= (nxt_idx == len_q);
                        stop_pend <= stop_pend | i_stop;
                    end else if (rep_q && !(stop_pend || i_stop)) begin
                        // Wrap straight into the next frame with no idle gap.
                        idx    <= '0;
                        o_val  <= pat_q[0];
                        o_last <= (len_q == '0);
                    end else begin
                        state     <= ST_IDLE;
                        idx       <= '0;
                        stop_pend <= 1'b0;
                        o_done    <= 1'b1;
                        o_ready   <= 1'b1;
                        o_valid   <= 1'b0;
                        o_val     <= 1'b0;
                        o_last    <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: expected output words are queued as each
// cycle of stimulus is driven and compared once the DUT has clocked it.
module tb_seq_gen;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    logic             clk;
    logic             rst_n;
    logic             i_load;
    logic [WIDTH-1:0] i_pattern;
    logic [CNT_W-1:0] i_len;
    logic             i_repeat;
    logic             i_stop;
    logic             o_ready;
    logic             o_valid;
    logic             o_val;
    logic             o_last;
    logic             o_done;

    int check_count = 0;
    int error_count = 0;
    logic [4:0] exp_q[$];

    seq_gen #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (i_load),
        .i_pattern(i_pattern),
        .i_len    (i_len),
        .i_repeat (i_repeat),
        .i_stop   (i_stop),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_val    (o_val),
        .o_last   (o_last),
        .o_done   (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the outputs as {ready, valid, val, last, done}.
    function automatic logic [4:0] exp_word(input logic rdy, input logic vld,
                                            input logic val, input logic lst,
                                            input logic dne);
        return {rdy, vld, val, lst, dne};
    endfunction

    task automatic checkOutput(input string tag, input logic [4:0] observed,
                               input logic [4:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got rdy/vld/val/last/done=%b expected %b",
                     tag, observed, expected);
        end
    endtask

    // One clock of stimulus: the caller sets inputs, the expected result of
    // this edge is queued, and it is checked half a cycle after the edge.
    task automatic applyStimulus(input string tag, input logic [4:0] expected);
        logic [4:0] want;
        exp_q.push_back(expected);
        @(posedge clk);
        @(negedge clk);
        want = exp_q.pop_front();
        checkOutput(tag, {o_ready, o_valid, o_val, o_last, o_done}, want);
        i_load = 1'b0;
        i_stop = 1'b0;
    endtask

    localparam logic [4:0] IDLE_W = 5'b10000;
    localparam logic [4:0] DONE_W = 5'b10001;
    localparam logic [4:0] RST_W  = 5'b00000;

    initial begin
        logic [31:0] pat;
        logic [3:0]  rpat;
        logic [2:0]  bpat;

        rst_n     = 1'b0;
        i_load    = 1'b0;
        i_pattern = '0;
        i_len     = '0;
        i_repeat  = 1'b0;
        i_stop    = 1'b0;

        // Reset held for two edges, then release.
        applyStimulus("rst0", RST_W);
        applyStimulus("rst1", RST_W);
        rst_n = 1'b1;
        applyStimulus("rel0", IDLE_W);
        i_stop = 1'b1;
        applyStimulus("idle_stop", IDLE_W);

        // Single-shot full-width frame; inputs scrambled after load.
        pat       = 32'b10101010101011001101100110101010;
        i_pattern = pat;
        i_len     = 5'd31;
        i_repeat  = 1'b0;
        i_load    = 1'b1;
        applyStimulus("ss0", exp_word(0, 1, pat[0], 0, 0));
        i_pattern = ~pat;
        i_len     = 5'd3;
        i_repeat  = 1'b1;
        for (int i = 1; i < 32; i++)
            applyStimulus($sformatf("ss%0d", i), exp_word(0, 1, pat[i], i == 31, 0));
        applyStimulus("ss_done", DONE_W);
        applyStimulus("ss_idle", IDLE_W);

        // Repeat with a stop pulse during bit 2 of frame 2.
        rpat      = 4'b1011;
        i_pattern = 32'(rpat);
        i_len     = 5'd3;
        i_repeat  = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                if (f == 0 && k == 0) i_load = 1'b1;
                if (f == 1 && k == 2) i_stop = 1'b1;
                applyStimulus($sformatf("rp_f%0d_b%0d", f, k),
                              exp_word(0, 1, rpat[k], k == 3, 0));
            end
        end
        applyStimulus("rp_done", DONE_W);
        applyStimulus("rp_idle", IDLE_W);

        // Stop raised exactly while o_last is high: no wrap.
        bpat      = 3'b110;
        i_pattern = 32'(bpat);
        i_len     = 5'd2;
        i_repeat  = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 3; k++) begin
                if (f == 0 && k == 0) i_load = 1'b1;
                applyStimulus($sformatf("sb_f%0d_b%0d", f, k),
                              exp_word(0, 1, bpat[k], k == 2, 0));
            end
        end
        i_stop = 1'b1;
        applyStimulus("sb_done", DONE_W);
        applyStimulus("sb_idle", IDLE_W);

        // Mid-frame load ignored, then back-to-back load in the done cycle.
        pat       = 32'h0000_003C;
        i_pattern = pat;
        i_len     = 5'd7;
        i_repeat  = 1'b0;
        i_load    = 1'b1;
        applyStimulus("ig0", exp_word(0, 1, pat[0], 0, 0));
        for (int i = 1; i < 8; i++) begin
            if (i == 3) begin
                i_load    = 1'b1;
                i_pattern = 32'h0000_00FF;
                i_repeat  = 1'b1;
            end
            applyStimulus($sformatf("ig%0d", i), exp_word(0, 1, pat[i], i == 7, 0));
        end
        applyStimulus("ig_done", DONE_W);
        pat       = 32'h0000_000F;
        i_pattern = pat;
        i_len     = 5'd7;
        i_repeat  = 1'b0;
        i_load    = 1'b1;
        applyStimulus("b2b0", exp_word(0, 1, 1'b1, 0, 0));
        for (int i = 1; i < 8; i++)
            applyStimulus($sformatf("b2b%0d", i), exp_word(0, 1, pat[i], i == 7, 0));
        applyStimulus("b2b_done", DONE_W);
        applyStimulus("b2b_idle", IDLE_W);

        // Reset in the middle of a frame abandons it without o_done.
        pat       = 32'hDEAD_BEEF;
        i_pattern = pat;
        i_len     = 5'd31;
        i_load    = 1'b1;
        applyStimulus("mr0", exp_word(0, 1, pat[0], 0, 0));
        for (int i = 1; i < 10; i++)
            applyStimulus($sformatf("mr%0d", i), exp_word(0, 1, pat[i], 0, 0));
        rst_n = 1'b0;
        applyStimulus("mr_rst", RST_W);
        rst_n = 1'b1;
        applyStimulus("mr_rel", IDLE_W);
        applyStimulus("mr_idle", IDLE_W);

        // Single-bit frame looping until stopped.
        i_pattern = 32'h0000_0003;
        i_len     = 5'd0;
        i_repeat  = 1'b1;
        i_load    = 1'b1;
        for (int i = 0; i < 6; i++)
            applyStimulus($sformatf("l0_%0d", i), exp_word(0, 1, 1, 1, 0));
        i_stop = 1'b1;
        applyStimulus("l0_done", DONE_W);
        applyStimulus("l0_idle", IDLE_W);

        if (exp_q.size() != 0) begin
            error_count++;
            $display("[TB] FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
